// File: rtl/psram_spi_responder.sv
// Device-side SPI mode-0 PSRAM responder: decodes read/fast-read/write/read-ID
// commands from oversampled pins and serves them from a synchronous byte RAM port.
`timescale 1ns/1ps
module psram_spi_responder #(
    parameter int          ADDR_W = 23,
    parameter logic [15:0] KGD_ID = 16'h0D5D,
    parameter int          DUMMY  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              psram_ce,
    input  logic              psram_sclk,
    input  logic              psram_mosi,
    output logic              psram_miso,
    output logic              miso_oe,
    output logic [ADDR_W-1:0] mem_a,
    output logic [7:0]        mem_d,
    output logic              mem_we,
    output logic              mem_rd,
    input  logic [7:0]        mem_q
);
    localparam int CNT_W = 5;

    typedef enum logic [2:0] {
        CMD, ADDR, DUMMY_S, FETCH, RDATA, WDATA, IDOUT, IGNORE
    } state_t;
    typedef enum logic [1:0] {OP_RD, OP_FAST, OP_WR, OP_ID} op_t;

    logic ce_s1_q, ce_s2_q, sclk_s1_q, sclk_s2_q, sclk_s3_q, mosi_s1_q, mosi_s2_q;
    logic rise, fall;

    state_t             state_q, state_d;
    op_t                op_q, op_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [6:0]         sreg_q, sreg_d;
    logic [7:0]         sreg_out_q, sreg_out_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               id_lo_q, id_lo_d;
    logic               load_q, load_d;
    logic               miso_q, miso_d;
    logic               miso_oe_q, miso_oe_d;
    logic               mem_we_q, mem_we_d;
    logic               mem_rd_q, mem_rd_d;
    logic [ADDR_W-1:0]  mem_a_q, mem_a_d;
    logic [7:0]         mem_d_q, mem_d_d;
    logic [7:0]         in_byte;

    assign rise    = !ce_s2_q && sclk_s2_q && !sclk_s3_q;
    assign fall    = !ce_s2_q && !sclk_s2_q && sclk_s3_q;
    assign in_byte = {sreg_q, mosi_s2_q};

    // A mem_rd strobe is answered on mem_q one clk later; load_q marks that clk.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        bit_cnt_d  = bit_cnt_q;
        sreg_d     = sreg_q;
        sreg_out_d = sreg_out_q;
        addr_d     = addr_q;
        id_lo_d    = id_lo_q;
        load_d     = mem_rd_q;
        miso_d     = miso_q;
        miso_oe_d  = miso_oe_q;
        mem_we_d   = 1'b0;
        mem_rd_d   = 1'b0;
        mem_a_d    = mem_a_q;
        mem_d_d    = mem_d_q;
        if (ce_s2_q) begin
            state_d   = CMD;
            bit_cnt_d = '0;
            miso_oe_d = 1'b0;
            miso_d    = 1'b0;
            load_d    = 1'b0;
        end else begin
            if (load_q) begin
                sreg_out_d = mem_q;
                addr_d     = addr_q + ADDR_W'(1);
            end
            unique case (state_q)
                CMD: if (rise) begin
                    sreg_d    = in_byte[6:0];
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == CNT_W'(7)) begin
                        bit_cnt_d = '0;
                        state_d   = ADDR;
                        case (in_byte)
                            8'h03:   op_d = OP_RD;
                            8'h0B:   op_d = OP_FAST;
                            8'h02:   op_d = OP_WR;
                            8'h9F:   op_d = OP_ID;
                            default: state_d = IGNORE;
                        endcase
                    end
                end
                ADDR: if (rise) begin
                    // Shifting 24 bits through ADDR_W bits drops the unused upper bits.
                    addr_d    = {addr_q[ADDR_W-2:0], mosi_s2_q};
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == CNT_W'(23)) begin
                        bit_cnt_d = '0;
                        case (op_q)
                            OP_RD:   state_d = FETCH;
                            OP_FAST: state_d = DUMMY_S;
                            OP_WR:   state_d = WDATA;
                            OP_ID: begin
                                state_d    = IDOUT;
                                sreg_out_d = KGD_ID[15:8];
                                id_lo_d    = 1'b1;
                                miso_oe_d  = 1'b1;
                            end
                        endcase
                    end
                end
                DUMMY_S: if (rise) begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == CNT_W'(DUMMY - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = FETCH;
                    end
                end
                FETCH: begin
                    mem_rd_d  = 1'b1;
                    mem_a_d   = addr_q;
                    miso_oe_d = 1'b1;
                    state_d   = RDATA;
                end
                RDATA: if (fall) begin
                    miso_d     = sreg_out_q[7];
                    sreg_out_d = {sreg_out_q[6:0], 1'b0};
                    bit_cnt_d  = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == CNT_W'(7)) begin
                        bit_cnt_d = '0;
                        mem_rd_d  = 1'b1;
                        mem_a_d   = addr_q;
                    end
                end
                WDATA: if (rise) begin
                    sreg_d    = in_byte[6:0];
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == CNT_W'(7)) begin
                        bit_cnt_d = '0;
                        mem_we_d  = 1'b1;
                        mem_a_d   = addr_q;
                        mem_d_d   = in_byte;
                        addr_d    = addr_q + ADDR_W'(1);
                    end
                end
                IDOUT: if (fall) begin
                    miso_d     = sreg_out_q[7];
                    sreg_out_d = {sreg_out_q[6:0], 1'b0};
                    bit_cnt_d  = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == CNT_W'(7)) begin
                        bit_cnt_d  = '0;
                        sreg_out_d = id_lo_q ? KGD_ID[7:0] : 8'h00;
                        id_lo_d    = 1'b0;
                    end
                end
                IGNORE: miso_oe_d = 1'b0;
                default: state_d = CMD;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ce_s1_q    <= 1'b1;
            ce_s2_q    <= 1'b1;
            sclk_s1_q  <= 1'b0;
            sclk_s2_q  <= 1'b0;
            sclk_s3_q  <= 1'b0;
            mosi_s1_q  <= 1'b0;
            mosi_s2_q  <= 1'b0;
            state_q    <= CMD;
            op_q       <= OP_RD;
            bit_cnt_q  <= '0;
            sreg_q     <= '0;
            sreg_out_q <= '0;
            addr_q     <= '0;
            id_lo_q    <= 1'b0;
            load_q     <= 1'b0;
            miso_q     <= 1'b0;
            miso_oe_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_a_q    <= '0;
            mem_d_q    <= '0;
        end else begin
            ce_s1_q    <= psram_ce;
            ce_s2_q    <= ce_s1_q;
            sclk_s1_q  <= psram_sclk;
            sclk_s2_q  <= sclk_s1_q;
            sclk_s3_q  <= sclk_s2_q;
            mosi_s1_q  <= psram_mosi;
            mosi_s2_q  <= mosi_s1_q;
            state_q    <= state_d;
            op_q       <= op_d;
            bit_cnt_q  <= bit_cnt_d;
            sreg_q     <= sreg_d;
            sreg_out_q <= sreg_out_d;
            addr_q     <= addr_d;
            id_lo_q    <= id_lo_d;
            load_q     <= load_d;
            miso_q     <= miso_d;
            miso_oe_q  <= miso_oe_d;
            mem_we_q   <= mem_we_d;
            mem_rd_q   <= mem_rd_d;
            mem_a_q    <= mem_a_d;
            mem_d_q    <= mem_d_d;
        end
    end

    assign psram_miso = miso_q;
    assign miso_oe    = miso_oe_q;
    assign mem_we     = mem_we_q;
    assign mem_rd     = mem_rd_q;
    assign mem_a      = mem_a_q;
    assign mem_d      = mem_d_q;
endmodule

// File: tb/tb_psram_spi_responder.sv
// Bench for psram_spi_responder: an SPI master driver, a byte-RAM model behind the
// memory port, and a reference memory image predicting every strobe and miso byte.
`timescale 1ns/1ps
module tb_psram_spi_responder;
    localparam int ADDR_W = 23;
    localparam int HALF   = 80;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef logic [7:0] byte_q_t[$];

    logic              clk, rst;
    logic              psram_ce, psram_sclk, psram_mosi, psram_miso, miso_oe;
    logic [ADDR_W-1:0] mem_a;
    logic [7:0]        mem_d, mem_q;
    logic              mem_we, mem_rd;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] ram       [0:DEPTH-1];
    logic [7:0] model_mem [0:DEPTH-1];

    logic [ADDR_W-1:0] obs_wa[$], obs_ra[$], exp_wa[$];
    logic [7:0]        obs_wd[$], exp_wd[$];
    int                both_cnt = 0;
    bit                oe_seen  = 1'b0;

    psram_spi_responder dut (
        .clk(clk), .rst(rst), .psram_ce(psram_ce), .psram_sclk(psram_sclk),
        .psram_mosi(psram_mosi), .psram_miso(psram_miso), .miso_oe(miso_oe),
        .mem_a(mem_a), .mem_d(mem_d), .mem_we(mem_we), .mem_rd(mem_rd), .mem_q(mem_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Backing RAM: synchronous read, data valid the clk after mem_rd.
    always @(posedge clk) begin
        if (mem_rd) mem_q <= ram[mem_a];
        if (mem_we) ram[mem_a] <= mem_d;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_we) begin
                obs_wa.push_back(mem_a);
                obs_wd.push_back(mem_d);
            end
            if (mem_rd) obs_ra.push_back(mem_a);
            if (mem_we && mem_rd) both_cnt++;
            if (miso_oe) oe_seen = 1'b1;
        end
    end

    function automatic logic [ADDR_W-1:0] addr_at(input logic [ADDR_W-1:0] a, input int i);
        return a + ADDR_W'(i);
    endfunction

    task automatic clear_obs();
        obs_wa.delete(); obs_wd.delete(); obs_ra.delete();
        exp_wa.delete(); exp_wd.delete();
        oe_seen = 1'b0;
    endtask

    task automatic spi_begin();
        psram_ce = 1'b0;
        #HALF;
    endtask

    task automatic spi_end();
        #HALF;
        psram_ce = 1'b1;
        #(5 * HALF);
    endtask

    task automatic spi_bit(input logic b, output logic r);
        psram_mosi = b;
        #HALF;
        psram_sclk = 1'b1;
        r = psram_miso;
        #HALF;
        psram_sclk = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(tx[i], r);
            rx[i] = r;
        end
    endtask

    // The 24th address bit is random: only the low ADDR_W bits may matter.
    task automatic spi_hdr(input logic [7:0] cmd, input logic [ADDR_W-1:0] a);
        logic [7:0]  rx;
        logic [23:0] a24;
        a24 = {1'($urandom), a};
        spi_byte(cmd, rx);
        spi_byte(a24[23:16], rx);
        spi_byte(a24[15:8], rx);
        spi_byte(a24[7:0], rx);
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input byte_q_t data);
        logic [7:0] rx;
        spi_begin();
        spi_hdr(8'h02, a);
        foreach (data[i]) begin
            spi_byte(data[i], rx);
            exp_wa.push_back(addr_at(a, i));
            exp_wd.push_back(data[i]);
            model_mem[addr_at(a, i)] = data[i];
        end
        spi_end();
    endtask

    task automatic do_read(input logic [7:0] cmd, input logic [ADDR_W-1:0] a, input int n,
                           output byte_q_t got);
        logic [7:0] rx;
        logic       r;
        got = {};
        spi_begin();
        spi_hdr(cmd, a);
        if (cmd == 8'h0B) for (int i = 0; i < 8; i++) spi_bit(1'($urandom), r);
        for (int i = 0; i < n; i++) begin
            spi_byte(8'($urandom), rx);
            got.push_back(rx);
        end
        spi_end();
    endtask

    task automatic test_reset();
        psram_ce = 1'b1; psram_sclk = 1'b0; psram_mosi = 1'b0; rst = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (psram_miso !== 1'b0) begin n_fail++; $display("FAIL reset_miso got %b exp 0", psram_miso); end
        n_cmp++; if (miso_oe !== 1'b0) begin n_fail++; $display("FAIL reset_oe got %b exp 0", miso_oe); end
        n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b exp 0", mem_we); end
        n_cmp++; if (mem_rd !== 1'b0) begin n_fail++; $display("FAIL reset_rd got %b exp 0", mem_rd); end
        n_cmp++; if (mem_a !== '0) begin n_fail++; $display("FAIL reset_a got %h exp 0", mem_a); end
        n_cmp++; if (mem_d !== 8'h00) begin n_fail++; $display("FAIL reset_d got %h exp 0", mem_d); end
    endtask

    task automatic test_write_one(input logic [ADDR_W-1:0] a, input byte_q_t data);
        clear_obs();
        do_write(a, data);
        n_cmp++;
        if (obs_wa.size() != exp_wa.size() || obs_ra.size() != 0) begin
            n_fail++;
            $display("FAIL write_count got we=%0d rd=%0d exp we=%0d rd=0",
                     obs_wa.size(), obs_ra.size(), exp_wa.size());
        end
        for (int i = 0; i < exp_wa.size() && i < obs_wa.size(); i++) begin
            n_cmp++;
            if (obs_wa[i] !== exp_wa[i] || obs_wd[i] !== exp_wd[i]) begin
                n_fail++;
                $display("FAIL write_%0d got a=%h d=%h exp a=%h d=%h",
                         i, obs_wa[i], obs_wd[i], exp_wa[i], exp_wd[i]);
            end
        end
    endtask

    task automatic test_write();
        byte_q_t d;
        test_write_one(23'h000010, '{8'hA5, 8'h3C});
        for (int k = 0; k < 3; k++) begin
            d = {};
            repeat ($urandom_range(1, 4)) d.push_back(8'($urandom));
            test_write_one(ADDR_W'($urandom), d);
        end
    endtask

    // Each fall-count multiple of 8 prefetches the next byte, so a read of n
    // bytes issues n+1 sequential mem_rd strobes starting at the command address.
    task automatic test_read_one(input logic [7:0] cmd, input logic [ADDR_W-1:0] a, input byte_q_t data);
        byte_q_t got;
        do_write(a, data);
        clear_obs();
        do_read(cmd, a, data.size(), got);
        for (int i = 0; i < data.size(); i++) begin
            n_cmp++;
            if (got[i] !== model_mem[addr_at(a, i)]) begin
                n_fail++;
                $display("FAIL read%h_byte%0d got %h exp %h", cmd, i, got[i], model_mem[addr_at(a, i)]);
            end
        end
        n_cmp++;
        if (obs_ra.size() != data.size() + 1 || obs_wa.size() != 0) begin
            n_fail++;
            $display("FAIL read%h_strobes got rd=%0d we=%0d exp rd=%0d we=0",
                     cmd, obs_ra.size(), obs_wa.size(), data.size() + 1);
        end
        for (int i = 0; i < obs_ra.size() && i <= data.size(); i++) begin
            n_cmp++;
            if (obs_ra[i] !== addr_at(a, i)) begin
                n_fail++;
                $display("FAIL read%h_addr%0d got %h exp %h", cmd, i, obs_ra[i], addr_at(a, i));
            end
        end
    endtask

    task automatic test_read();
        byte_q_t d;
        test_read_one(8'h03, 23'h000020, '{8'h11, 8'h22, 8'h33, 8'h44});
        for (int k = 0; k < 2; k++) begin
            d = {};
            repeat ($urandom_range(1, 4)) d.push_back(8'($urandom));
            test_read_one(8'h03, ADDR_W'($urandom), d);
        end
    endtask

    task automatic test_fast_read();
        test_read_one(8'h0B, 23'h7FFFFF, '{8'($urandom), 8'($urandom)});
        test_read_one(8'h0B, 23'h7FFFFE, '{8'($urandom), 8'($urandom), 8'($urandom)});
    endtask

    task automatic test_read_id();
        byte_q_t got;
        clear_obs();
        do_read(8'h9F, ADDR_W'($urandom), 3, got);
        n_cmp++; if (got[0] !== 8'h0D) begin n_fail++; $display("FAIL id_mfid got %h exp 0d", got[0]); end
        n_cmp++; if (got[1] !== 8'h5D) begin n_fail++; $display("FAIL id_kgd got %h exp 5d", got[1]); end
        n_cmp++; if (got[2] !== 8'h00) begin n_fail++; $display("FAIL id_tail got %h exp 00", got[2]); end
        n_cmp++;
        if (obs_ra.size() != 0 || obs_wa.size() != 0) begin
            n_fail++;
            $display("FAIL id_strobes got rd=%0d we=%0d exp 0 0", obs_ra.size(), obs_wa.size());
        end
    endtask

    task automatic test_write_abort();
        logic [ADDR_W-1:0] a;
        logic [7:0]        b0, rx;
        logic              r;
        byte_q_t           got;
        a  = ADDR_W'($urandom);
        b0 = 8'($urandom);
        clear_obs();
        spi_begin();
        spi_hdr(8'h02, a);
        spi_byte(b0, rx);
        model_mem[a] = b0;
        for (int i = 0; i < 4; i++) spi_bit(1'($urandom), r);
        spi_end();
        n_cmp++;
        if (obs_wa.size() != 1) begin
            n_fail++; $display("FAIL abort_we_count got %0d exp 1", obs_wa.size());
        end else begin
            n_cmp++;
            if (obs_wa[0] !== a || obs_wd[0] !== b0) begin
                n_fail++; $display("FAIL abort_we got a=%h d=%h exp a=%h d=%h", obs_wa[0], obs_wd[0], a, b0);
            end
        end
        do_read(8'h03, a, 1, got);
        n_cmp++; if (got[0] !== b0) begin n_fail++; $display("FAIL abort_readback got %h exp %h", got[0], b0); end
    endtask

    task automatic test_ignore_and_reset();
        logic [ADDR_W-1:0] a;
        logic [7:0]        rx;
        logic              r;
        byte_q_t           got;
        clear_obs();
        spi_begin();
        spi_byte(8'h5A, rx);
        repeat (3) spi_byte(8'($urandom), rx);
        spi_end();
        n_cmp++;
        if (obs_wa.size() != 0 || obs_ra.size() != 0 || oe_seen) begin
            n_fail++;
            $display("FAIL unknown_cmd got we=%0d rd=%0d oe=%b exp 0 0 0", obs_wa.size(), obs_ra.size(), oe_seen);
        end
        a = ADDR_W'($urandom);
        do_write(a, '{8'($urandom), 8'($urandom)});
        spi_begin();
        spi_hdr(8'h03, a);
        spi_byte(8'h00, rx);
        n_cmp++; if (rx !== model_mem[a]) begin n_fail++; $display("FAIL pre_rst_byte got %h exp %h", rx, model_mem[a]); end
        for (int i = 0; i < 4; i++) spi_bit(1'b0, r);
        rst = 1'b1;
        clear_obs();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        n_cmp++; if (miso_oe !== 1'b0) begin n_fail++; $display("FAIL rst_mid_oe got %b exp 0", miso_oe); end
        n_cmp++;
        if (obs_wa.size() != 0 || obs_ra.size() != 0) begin
            n_fail++; $display("FAIL rst_mid_strobes got we=%0d rd=%0d exp 0 0", obs_wa.size(), obs_ra.size());
        end
        spi_end();
        do_read(8'h03, a, 2, got);
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (got[i] !== model_mem[addr_at(a, i)]) begin
                n_fail++; $display("FAIL post_rst_byte%0d got %h exp %h", i, got[i], model_mem[addr_at(a, i)]);
            end
        end
    endtask

    task automatic test_back_to_back();
        byte_q_t d;
        logic [ADDR_W-1:0] a;
        for (int k = 0; k < 4; k++) begin
            d = {};
            repeat ($urandom_range(1, 4)) d.push_back(8'($urandom));
            a = (k == 0) ? 23'h7FFFFD : ADDR_W'($urandom);
            test_read_one(($urandom_range(0, 1) == 1) ? 8'h0B : 8'h03, a, d);
        end
        n_cmp++;
        if (both_cnt != 0) begin n_fail++; $display("FAIL we_rd_overlap got %0d exp 0", both_cnt); end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_fast_read();
        test_read_id();
        test_write_abort();
        test_ignore_and_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
